// File: rtl/bcd_digit_feeder.sv
// Accepts a 16-bit value, converts it to BCD with a sequential double-dabble or passes hex nibbles,
// and presents one display digit per clock in lockstep with the 7-segment scan.
module bcd_digit_feeder #(
    parameter int         DIN_W    = 16,
    parameter int         MAX_VAL  = 9999,
    parameter logic [3:0] OVF_CODE = 4'hE
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DIN_W-1:0] i_data,
    input  logic             i_hex,
    output logic             o_done,
    output logic [1:0]       o_digit_idx,
    output logic [4:0]       o_bcd_data
);

    localparam int               CNT_W = $clog2(DIN_W) + 1;
    localparam logic [DIN_W-1:0] MAX_V = DIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIN_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [DIN_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      disp_q, disp_d;
    logic             done_q, done_d;
    logic [1:0]       idx_q;
    logic [15:0]      adj;

    // Handshake: a value is taken on any edge where i_valid & o_ready; o_ready is high only in IDLE,
    // and i_valid while o_ready is low is dropped, never queued.
    assign o_ready     = (state_q == IDLE);
    assign o_done      = done_q;
    assign o_digit_idx = idx_q;
    assign o_bcd_data  = {1'b0, disp_q[4*idx_q +: 4]};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (i_hex) begin
                        disp_d = 16'(i_data);
                        done_d = 1'b1;
                    end else if (i_data > MAX_V) begin
                        ovf_d   = 1'b1;
                        state_d = COMMIT;
                    end else begin
                        bcd_d   = '0;
                        bin_d   = i_data;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_d = {adj[14:0], bin_q[DIN_W-1]};
                bin_d = {bin_q[DIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = ovf_q ? {4{OVF_CODE}} : bcd_q;
                done_d  = 1'b1;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            done_q  <= done_d;
            idx_q   <= idx_q + 2'd1;
        end
    end

endmodule
